ntt_sdf_reorder: RTL and testbench
==================================

Name: ntt_sdf_reorder

Overview:
- Output-side consumer of the SDF NTT pipeline.
- Takes the serial coefficient stream and its frame-start pulse from the last pipeline stage. The stream is in bit-reversed order.
- Reorders each N=2^LOGN frame in a ping-pong buffer and emits it in natural order with a start pulse and valid strobe.
- Allows back-to-back frames at one word per cycle.

Parameters:
- LOGQ, 32, coefficient width in bits.
- LOGN, 8, log2 of frame length N.
- DELAY_BRAM, 2, buffer read latency in cycles (1..4), from read address to registered output.

Ports:
- clk, input, 1, single clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_start, input, 1, one-cycle pulse coincident with word 0 of a frame (driven by the NTT finish).
- in_bitrev, input, 1, sampled with in_start. 1 = frame arrives bit-reversed (reorder it); 0 = frame already natural (pass order through).
- din, input, LOGQ, coefficient; valid on the in_start cycle and each of the following N-1 cycles.
- out_start, output, 1, one-cycle pulse coincident with natural-order word 0.
- out_valid, output, 1, high for exactly N consecutive cycles per frame.
- dout, output, LOGQ, reordered coefficient.
- busy, output, 1, high while any frame is being written or read.

Behaviour:
- Reset (rst_n low, async):
  - out_start, out_valid, busy = 0; dout = 0.
  - Write counter, read counter, bank pointers and bank-full flags cleared.
  - Buffer contents are don't-care.
  - Reset mid-frame discards both banks; the next in_start begins a fresh frame.
- Storage: two banks of N x LOGQ (inferred BRAM). wr_bank and rd_bank pointers, one full flag per bank.
- Write FSM, states W_IDLE and W_FILL:
  - W_IDLE to W_FILL on in_start, if the target bank is not full. Word 0 is written in the same cycle; wcnt = 1.
  - W_FILL: each cycle, write din at address bitrev(wcnt) if the latched in_bitrev = 1, else at wcnt; wcnt increments.
  - On the write of word N-1: set full[wr_bank], toggle wr_bank, return to W_IDLE.
  - in_start during W_FILL: the partial frame is discarded and writing restarts at word 0 in the same bank. The status event is flagged (see Optional Feature).
  - in_start while the target bank is still full (reader not done): frame dropped, no write, state stays W_IDLE, status event flagged.
- Read FSM, states R_IDLE and R_DRAIN:
  - R_IDLE to R_DRAIN when full[rd_bank] = 1. Read addresses 0..N-1 are issued in natural order, one per cycle.
  - Data appears on dout DELAY_BRAM cycles after its address. out_valid is delayed to match; out_start accompanies address 0.
  - When address N-1 is issued: clear full[rd_bank], toggle rd_bank.
  - If the other bank is already full, address 0 of the next frame issues the following cycle, so out_valid stays continuously high.
- Latency:
  - in_start at cycle 0, last word written cycle N-1, read address 0 at cycle N.
  - out_start at cycle N+DELAY_BRAM when the reader was idle.
- Simultaneous events:
  - Write of word N-1 and read of the last address of the other bank in the same cycle: both flag updates apply; no lost frame.
  - Same-bank write/read cannot occur (full-flag interlock).
- busy = W_FILL, or R_DRAIN, or any full flag set, or the output pipeline non-empty.

Optional Feature:
- Macro: NTT_SDF_REORDER_STATUS_EN.
- When defined, two extra outputs are added:
  - err (1 bit, sticky until reset): set on a dropped frame or on a restarted partial frame.
  - frame_cnt (16 bits, wrapping): increments once per completed out_valid frame.
- When undefined, neither port exists and the events are silently ignored. Data behaviour is identical either way.

Test Plan (LOGN=3, N=8, DELAY_BRAM=2, LOGQ=32):
- Single frame: in_start at cycle 0, in_bitrev=1, din 0,4,2,6,1,5,3,7 → out_start at cycle 10, dout 0..7 on cycles 10..17, out_valid low from cycle 18, busy drops after.
- Passthrough: in_bitrev=0, din 10..17 → dout 10..17 in order, starting at cycle 10.
- Back-to-back: three frames with in_start at cycles 0, 8, 16 → out_valid continuously high cycles 10..33, out_start pulses at 10, 18, 26, data correct per frame.
- Overflow: frames at cycles 0 and 8, plus a third in_start at cycle 9 restarting a partial frame → first two frames output correctly. The aborted frame produces no output. err=1 with NTT_SDF_REORDER_STATUS_EN.
- Reset mid-operation: rst_n low at cycle 5 of a frame, released at cycle 7 → all outputs 0 immediately. A new frame at cycle 12 outputs correctly starting at cycle 22, with no residue of the aborted frame.
- Status: with the macro defined, run 3 frames → frame_cnt = 3, err = 0.

Source files
------------

// File: rtl/ntt_sdf_reorder.sv
// -----------------------------------------------------------------------------
// ntt_sdf_reorder
//
// Output-side reorder buffer for the SDF NTT pipeline. A serial coefficient
// stream arrives one word per cycle, framed by i_in_start. It is usually in
// bit-reversed order. Each N = 2**LOGN frame is written into one bank of a
// ping-pong buffer. Once the bank is full it is drained in natural order.
// Back-to-back frames run at one word per cycle with no gap on the output.
//
// Optional feature (macro NTT_SDF_REORDER_STATUS_EN):
//   Adds o_err, a sticky flag set on a dropped or restarted frame.
//   Adds o_frame_cnt, a wrapping count of completed output frames.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_in_start   in   pulse with word 0 of an incoming frame
//   i_in_bitrev  in   sampled with i_in_start; 1 = frame arrives bit-reversed
//   i_din        in   incoming coefficient [LOGQ-1:0]
//   o_out_start  out  pulse with natural-order word 0
//   o_out_valid  out  high for N consecutive cycles per frame
//   o_dout       out  reordered coefficient [LOGQ-1:0], zero when not valid
//   o_busy       out  a frame is being written, held, read or in flight
//   o_err        out  (status build only) sticky drop/restart flag
//   o_frame_cnt  out  (status build only) completed output frames [15:0]
//
// Handshake: there is no back-pressure. Once i_in_start is accepted the source
// presents one word per cycle for N cycles. The sink must accept every cycle
// on which o_out_valid is high.
// -----------------------------------------------------------------------------
module ntt_sdf_reorder #(
    parameter int LOGQ       = 32,
    parameter int LOGN       = 8,
    parameter int DELAY_BRAM = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_start,
    input  logic            i_in_bitrev,
    input  logic [LOGQ-1:0] i_din,
    output logic            o_out_start,
    output logic            o_out_valid,
    output logic [LOGQ-1:0] o_dout,
    output logic            o_busy
`ifdef NTT_SDF_REORDER_STATUS_EN
    ,
    output logic            o_err,
    output logic [15:0]     o_frame_cnt
`endif
);

    localparam int N = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
    localparam logic [LOGN-1:0] ONE  = LOGN'(1);
    localparam logic [LOGN-1:0] ZERO = '0;

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    function automatic logic [LOGN-1:0] f_bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    // Storage: bank select is the address MSB.
    logic [LOGQ-1:0] r_mem [2*N];

    wstate_t         r_wstate;
    logic [LOGN-1:0] r_wcnt;
    logic            r_wbitrev;
    logic            r_wr_bank;

    rstate_t         r_rstate;
    logic [LOGN-1:0] r_rcnt;
    logic            r_rd_bank;

    logic [1:0]      r_full;

    logic [DELAY_BRAM-1:0] r_vpipe;
    logic [DELAY_BRAM-1:0] r_spipe;
    logic [LOGQ-1:0]       r_dpipe [DELAY_BRAM];

    logic            w_we;
    logic [LOGN:0]   w_waddr;
    logic            w_set_full;
    logic            w_rd_issue;
    logic            w_rd_last;

    // ---------------- write side ----------------
    // Word 0 always lands at address 0, because bitrev(0) == 0.
    always_comb begin
        w_we       = 1'b0;
        w_waddr    = {r_wr_bank, ZERO};
        w_set_full = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (i_in_start && !r_full[r_wr_bank]) begin
                    w_we = 1'b1;
                end
            end
            W_FILL: begin
                w_we = 1'b1;
                if (!i_in_start) begin
                    w_waddr    = {r_wr_bank, (r_wbitrev ? f_bitrev(r_wcnt) : r_wcnt)};
                    w_set_full = (r_wcnt == LAST);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_wcnt    <= '0;
            r_wbitrev <= 1'b0;
            r_wr_bank <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (i_in_start && !r_full[r_wr_bank]) begin
                        r_wcnt    <= ONE;
                        r_wbitrev <= i_in_bitrev;
                        r_wstate  <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (i_in_start) begin
                        // A new frame arriving early discards the partial one.
                        // The new frame restarts in the same bank.
                        r_wcnt    <= ONE;
                        r_wbitrev <= i_in_bitrev;
                    end else if (r_wcnt == LAST) begin
                        r_wcnt    <= '0;
                        r_wr_bank <= ~r_wr_bank;
                        r_wstate  <= W_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + ONE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    // An address issues in every cycle that the current read bank is full.
    // The flag stays set until the last address of the frame has issued.
    // When the other bank is already full, its address 0 follows directly.
    assign w_rd_issue = r_full[r_rd_bank];
    assign w_rd_last  = w_rd_issue && (r_rcnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_rd_issue) begin
            if (r_rcnt == LAST) begin
                r_rcnt    <= '0;
                r_rd_bank <= ~r_rd_bank;
                r_rstate  <= R_IDLE;
            end else begin
                r_rcnt   <= r_rcnt + ONE;
                r_rstate <= R_DRAIN;
            end
        end
    end

    // Set and clear can fire together only on different banks.
    // The full-flag interlock keeps the writer out of a bank still being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            if (w_set_full) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_rd_last) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    // ---------------- output pipeline ----------------
    // Stage 0 is the buffer read register. The remaining stages pad the
    // latency to DELAY_BRAM. Data is zeroed when no address issued, so a
    // stale buffer read never appears on o_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe <= '0;
            r_spipe <= '0;
            for (int i = 0; i < DELAY_BRAM; i++) begin
                r_dpipe[i] <= '0;
            end
        end else begin
            r_vpipe[0] <= w_rd_issue;
            r_spipe[0] <= w_rd_issue && (r_rcnt == ZERO);
            r_dpipe[0] <= w_rd_issue ? r_mem[{r_rd_bank, r_rcnt}] : '0;
            for (int i = 1; i < DELAY_BRAM; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_spipe[i] <= r_spipe[i-1];
                r_dpipe[i] <= r_dpipe[i-1];
            end
        end
    end

    assign o_out_valid = r_vpipe[DELAY_BRAM-1];
    assign o_out_start = r_spipe[DELAY_BRAM-1];
    assign o_dout      = r_dpipe[DELAY_BRAM-1];
    assign o_busy      = (r_wstate == W_FILL) || (r_rstate == R_DRAIN) ||
                         (|r_full) || (|r_vpipe);

`ifdef NTT_SDF_REORDER_STATUS_EN
    // Event: a frame is dropped because its bank is still full, or a
    // partial frame is abandoned by an early i_in_start.
    logic                  w_evt;
    logic [DELAY_BRAM-1:0] r_lpipe;
    logic                  r_err;
    logic [15:0]           r_frame_cnt;

    assign w_evt = i_in_start &&
                   ((r_wstate == W_FILL) || r_full[r_wr_bank]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lpipe     <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_lpipe[0] <= w_rd_last;
            for (int i = 1; i < DELAY_BRAM; i++) begin
                r_lpipe[i] <= r_lpipe[i-1];
            end
            if (w_evt) begin
                r_err <= 1'b1;
            end
            if (r_lpipe[DELAY_BRAM-1]) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_err       = r_err;
    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_ntt_sdf_reorder.sv
// Directed bench for ntt_sdf_reorder with N = 8 and DELAY_BRAM = 2.
// Cycle c is the interval that begins at the c-th rising edge after reset.
// Inputs for cycle c are driven at that interval's falling edge.
// Outputs for cycle c are sampled 1 ns later.
module tb_ntt_sdf_reorder;

  localparam int LOGQ = 32;
  localparam int LOGN = 3;
  localparam int DB   = 2;
  localparam int TMAX = 64;

  logic            clk;
  logic            rst_n;
  logic            in_start;
  logic            in_bitrev;
  logic [LOGQ-1:0] din;
  logic            out_start;
  logic            out_valid;
  logic [LOGQ-1:0] dout;
  logic            busy;
`ifdef NTT_SDF_REORDER_STATUS_EN
  logic            err;
  logic [15:0]     frame_cnt;
`endif

  int n_checks;
  int n_fail;

  // per-cycle stimulus and expectation tables
  logic        st_start [TMAX];
  logic        st_brev  [TMAX];
  logic [31:0] st_din   [TMAX];
  logic        st_rst   [TMAX];
  logic        exp_v    [TMAX];
  logic        exp_s    [TMAX];
  logic [31:0] exp_d    [TMAX];
  logic        chk_d    [TMAX];
  int          exp_b    [TMAX];

  ntt_sdf_reorder #(
    .LOGQ(LOGQ),
    .LOGN(LOGN),
    .DELAY_BRAM(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_in_start(in_start),
    .i_in_bitrev(in_bitrev),
    .i_din(din),
    .o_out_start(out_start),
    .o_out_valid(out_valid),
    .o_dout(dout),
    .o_busy(busy)
`ifdef NTT_SDF_REORDER_STATUS_EN
    ,
    .o_err(err),
    .o_frame_cnt(frame_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    in_start  = 1'b0;
    in_bitrev = 1'b0;
    din       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // table helpers
  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic clear_tables();
    for (int c = 0; c < TMAX; c++) begin
      st_start[c] = 1'b0;
      st_brev[c]  = 1'b0;
      st_din[c]   = '0;
      st_rst[c]   = 1'b0;
      exp_v[c]    = 1'b0;
      exp_s[c]    = 1'b0;
      exp_d[c]    = '0;
      chk_d[c]    = 1'b0;
      exp_b[c]    = -1;
    end
  endtask

  // Frame value k (natural index) is base+k; bit-reversed frames send it in rev order.
  task automatic put_frame(input int c0, input logic brev, input int base);
    st_start[c0] = 1'b1;
    st_brev[c0]  = brev;
    for (int k = 0; k < 8; k++) begin
      st_din[c0+k] = 32'(base + (brev ? rev3(k) : k));
    end
  endtask

  task automatic exp_word(input int c, input logic first, input int val);
    exp_v[c] = 1'b1;
    exp_s[c] = first;
    exp_d[c] = 32'(val);
    chk_d[c] = 1'b1;
  endtask

  task automatic exp_frame(input int c0, input int base);
    for (int k = 0; k < 8; k++) begin
      exp_word(c0 + k, (k == 0), base + k);
    end
  endtask

  // driver + per-cycle comparison
  task automatic run(input string name, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rst_n     = ~st_rst[c];
      in_start  = st_start[c];
      in_bitrev = st_brev[c];
      din       = st_din[c];
      #1;
      check($sformatf("%s_c%0d_valid", name, c), {31'd0, out_valid}, {31'd0, exp_v[c]});
      check($sformatf("%s_c%0d_start", name, c), {31'd0, out_start}, {31'd0, exp_s[c]});
      if (chk_d[c]) check($sformatf("%s_c%0d_dout", name, c), dout, exp_d[c]);
      if (exp_b[c] >= 0) check($sformatf("%s_c%0d_busy", name, c), {31'd0, busy}, 32'(exp_b[c]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // reset state
    do_reset();
    @(negedge clk);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_start", {31'd0, out_start}, 32'd0);
    check("reset_dout", dout, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // single bit-reversed frame: 0,4,2,6,1,5,3,7 -> 0..7 at cycles 10..17
    do_reset();
    clear_tables();
    put_frame(0, 1'b1, 0);
    exp_frame(10, 0);
    exp_b[0] = 0;
    exp_b[5] = 1;
    exp_b[17] = 1;
    for (int c = 18; c < 22; c++) exp_b[c] = 0;
    run("single", 22);
`ifdef NTT_SDF_REORDER_STATUS_EN
    check("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("single_err", {31'd0, err}, 32'd0);
`endif

    // passthrough: natural order 10..17
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 10);
    exp_frame(10, 10);
    run("pass", 20);

    // three back-to-back frames, output continuous 10..33
    do_reset();
    clear_tables();
    put_frame(0, 1'b1, 32'h100);
    put_frame(8, 1'b0, 32'h200);
    put_frame(16, 1'b1, 32'h300);
    exp_frame(10, 32'h100);
    exp_frame(18, 32'h200);
    exp_frame(26, 32'h300);
    for (int c = 34; c < 38; c++) exp_b[c] = 0;
    run("b2b", 38);
`ifdef NTT_SDF_REORDER_STATUS_EN
    check("status_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check("status_err", {31'd0, err}, 32'd0);
`endif

    // restart: word 0 of a frame at 8, new in_start at 9 aborts it
    do_reset();
    clear_tables();
    put_frame(0, 1'b1, 32'h400);
    st_start[8] = 1'b1;
    st_brev[8]  = 1'b1;
    st_din[8]   = 32'hdead;
    put_frame(9, 1'b1, 32'h500);
    exp_frame(10, 32'h400);
    exp_frame(19, 32'h500);
    run("restart", 32);
`ifdef NTT_SDF_REORDER_STATUS_EN
    check("restart_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("restart_err", {31'd0, err}, 32'd1);
`endif

    // reset during frame B (cycle 5 of B = 13), released at cycle 15;
    // frame A output is cut after cycle 12, fresh frame at 20 outputs from 30
    do_reset();
    clear_tables();
    put_frame(0, 1'b1, 32'h700);
    put_frame(8, 1'b0, 32'h710);
    st_rst[13] = 1'b1;
    st_rst[14] = 1'b1;
    exp_word(10, 1'b1, 32'h700);
    exp_word(11, 1'b0, 32'h701);
    exp_word(12, 1'b0, 32'h702);
    exp_b[12] = 1;
    for (int c = 13; c < 15; c++) begin
      chk_d[c] = 1'b1;
      exp_b[c] = 0;
    end
    exp_b[19] = 0;
    put_frame(20, 1'b1, 32'h720);
    exp_frame(30, 32'h720);
    run("rstmid", 42);
`ifdef NTT_SDF_REORDER_STATUS_EN
    check("rstmid_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("rstmid_err", {31'd0, err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
